// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Holds the FSM state encoding and the default parameter values.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        SEND    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_PKT_W       = 240;
    localparam int DEF_TIMEOUT_CYC = 2000000;
    localparam int TIMER_W         = 32;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin priority encoder.
// The first requester at or after ptr, wrapping modulo NUM_REQ, wins.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    logic [NUM_REQ-1:0] w_rot;
    logic [IDX_W-1:0]   w_pos [NUM_REQ];

    // Slot gi of the rotated view holds requester (ptr + gi) mod NUM_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign w_pos[gi] = (int'(ptr) + gi >= NUM_REQ) ?
                               IDX_W'(int'(ptr) + gi - NUM_REQ) :
                               IDX_W'(int'(ptr) + gi);
            assign w_rot[gi] = req[w_pos[gi]];
        end
    endgenerate

    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                valid = 1'b1;
                index = w_pos[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one serial sender among NUM_REQ packet sources.
// Each grant runs IDLE -> GRANT -> SEND -> RELEASE, with a timeout on the sender.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int PKT_W       = DEF_PKT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*PKT_W-1:0] pkt,
    output logic [NUM_REQ-1:0]       done,
    output logic [NUM_REQ-1:0]       err,
    output logic                     busy,
    output logic [PKT_W-1:0]         snd_data,
    output logic                     snd_start,
    input  logic                     snd_done
);

    localparam int                 IDX_W    = $clog2(NUM_REQ);
    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    state_t               r_state, w_state_next;
    logic [IDX_W-1:0]     r_ptr, w_ptr_next;
    logic [IDX_W-1:0]     r_winner, w_winner_next;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_pick_valid;
    logic [TIMER_W-1:0]   r_timer, w_timer_next;
    logic                 w_timeout;
    logic [NUM_REQ-1:0]   r_done, w_done_next;
    logic [NUM_REQ-1:0]   r_err, w_err_next;
    logic                 r_busy, w_busy_next;
    logic                 r_snd_start, w_snd_start_next;
    logic [PKT_W-1:0]     r_snd_data, w_snd_data_next;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .index (w_pick_idx)
    );

    assign w_timeout = (r_timer == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_pick_valid) w_state_next = GRANT;
            GRANT:   w_state_next = SEND;
            SEND:    if (snd_done || w_timeout) w_state_next = RELEASE;
            RELEASE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they line up with the state register.
    always_comb begin
        w_ptr_next       = r_ptr;
        w_winner_next    = r_winner;
        w_timer_next     = '0;
        w_snd_data_next  = r_snd_data;
        w_done_next      = '0;
        w_err_next       = '0;
        w_busy_next      = (w_state_next != IDLE);
        w_snd_start_next = (w_state_next == SEND);
        case (r_state)
            IDLE:    if (w_pick_valid) w_winner_next = w_pick_idx;
            GRANT:   w_snd_data_next = pkt[int'(r_winner)*PKT_W +: PKT_W];
            SEND: begin
                if (snd_done)       w_done_next[r_winner] = 1'b1;
                else if (w_timeout) w_err_next[r_winner]  = 1'b1;
                else                w_timer_next = r_timer + 1'b1;
            end
            RELEASE: w_ptr_next = (r_winner == IDX_W'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_winner    <= '0;
            r_timer     <= '0;
            r_snd_data  <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_busy      <= 1'b0;
            r_snd_start <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_next;
            r_winner    <= w_winner_next;
            r_timer     <= w_timer_next;
            r_snd_data  <= w_snd_data_next;
            r_done      <= w_done_next;
            r_err       <= w_err_next;
            r_busy      <= w_busy_next;
            r_snd_start <= w_snd_start_next;
        end
    end

    assign done      = r_done;
    assign err       = r_err;
    assign busy      = r_busy;
    assign snd_data  = r_snd_data;
    assign snd_start = r_snd_start;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized transfers,
// compared against a round-robin reference model kept in the bench.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 240;
    localparam int T = 100;

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b1;
    logic [N-1:0]   req      = '0;
    logic [N*W-1:0] pkt      = '0;
    logic           snd_done = 1'b0;
    logic [N-1:0]   done;
    logic [N-1:0]   err;
    logic           busy;
    logic [W-1:0]   snd_data;
    logic           snd_start;

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .PKT_W       (W),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .pkt       (pkt),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .snd_data  (snd_data),
        .snd_start (snd_start),
        .snd_done  (snd_done)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_pkt();
        for (int i = 0; i < N*W/32; i++) pkt[i*32 +: 32] = $urandom;
    endtask

    // First requesting index at or after p, wrapping.
    function automatic int rr_model(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // One grant from an IDLE negedge. lat: snd_start cycle on which snd_done is
    // raised (outside 1..T means never). Returns at the IDLE negedge after RELEASE.
    task automatic xfer(input string tag, input int lat, input bit hold, input bit disturb);
        int           w, cyc, hi, exp_hi;
        bit           ok;
        logic [W-1:0] exp_data;
        logic [N-1:0] exp_done, exp_err;
        w        = rr_model(req, m_ptr);
        exp_data = pkt[w*W +: W];
        ok       = (lat >= 1 && lat <= T);
        exp_hi   = ok ? lat : T;
        exp_done = '0;
        exp_err  = '0;
        if (ok) exp_done[w] = 1'b1;
        else    exp_err[w]  = 1'b1;
        cyc = 0;
        while (snd_start !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " start_lat"}, cyc, 2);
        if (snd_start !== 1'b1) return;
        chk({tag, " snd_data"}, snd_data, exp_data);
        hi = 0;
        while (snd_start === 1'b1 && hi < T + 10) begin
            hi++;
            if (hi == lat) snd_done = 1'b1;
            if (disturb && hi == 3) begin
                req[w]       = 1'b0;
                pkt[w*W +: W] = ~exp_data;
            end
            @(negedge clk);
            snd_done = 1'b0;
        end
        chk({tag, " start_cycles"}, hi, exp_hi);
        chk({tag, " done_pulse"}, done, exp_done);
        chk({tag, " err_pulse"}, err, exp_err);
        chk({tag, " data_hold"}, snd_data, exp_data);
        if (!hold) req[w] = 1'b0;
        m_ptr = (w + 1) % N;
        @(negedge clk);
        chk({tag, " done_clear"}, done, 0);
        chk({tag, " err_clear"}, err, 0);
        chk({tag, " idle_gap"}, busy, 0);
    endtask

    initial begin
        int cyc;
        #1 rst_n = 1'b0;
        #1;
        chk("reset busy", busy, 0);
        chk("reset snd_start", snd_start, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        chk("reset snd_data", snd_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Stray sender completion while idle
        snd_done = 1'b1;
        @(negedge clk);
        snd_done = 1'b0;
        chk("stray busy", busy, 0);
        chk("stray done", done, 0);
        @(negedge clk);
        chk("stray idle", busy, 0);

        // Single requester 2, sender finishes after 50 cycles
        rand_pkt();
        pkt[2*W + W - 8 +: 8] = 8'hA5;
        req = 4'b0100;
        xfer("single2", 50, 1'b0, 1'b0);

        // Reset in the middle of SEND
        rand_pkt();
        req = 4'b0010;
        cyc = 0;
        while (snd_start !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst reached_send", snd_start, 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst snd_start", snd_start, 0);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst err", err, 0);
        chk("midrst snd_data", snd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        req   = 4'b1010;
        xfer("after_rst", 20, 1'b0, 1'b0);
        req = '0;

        // Requester 3 alone, leaving the pointer wrapped to 0
        rand_pkt();
        req = 4'b1000;
        xfer("wrap3", 10, 1'b0, 1'b0);

        // All four held: grants 0,1,2,3,0
        rand_pkt();
        req = 4'b1111;
        for (int n = 0; n < 5; n++)
            xfer($sformatf("all%0d", n), int'($urandom_range(1, 30)), 1'b1, 1'b0);
        req = '0;
        @(negedge clk);

        // Sender never completes
        rand_pkt();
        req = 4'b0101;
        xfer("timeout", 0, 1'b0, 1'b0);
        req = '0;

        // Completion coincident with the last timeout cycle
        rand_pkt();
        req = 4'b0010;
        xfer("coincide", T, 1'b0, 1'b0);
        req = '0;

        // Packet changed and request dropped during SEND
        rand_pkt();
        req = 4'b1001;
        xfer("disturb", 40, 1'b0, 1'b1);
        req = '0;

        // Randomized traffic
        for (int n = 0; n < 10; n++) begin
            rand_pkt();
            req = N'($urandom_range(1, 15));
            xfer($sformatf("rnd%0d", n), int'($urandom_range(1, 130)),
                 1'($urandom_range(0, 1)), 1'b0);
        end
        req = '0;
        repeat (3) @(negedge clk);
        chk("final idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters; legal range 2..8.
REQ-002 Parameter PKT_W, default 240, packaged packet width in bits (30 UART bytes).
REQ-003 Parameter TIMEOUT_CYC, default 2000000, maximum cycles spent waiting for sender completion.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NUM_REQ  per-requester send request; level; held high until that requester's done or err.
REQ-007 pkt  input  NUM_REQ*PKT_W  packed packets; requester i at bits [i*PKT_W +: PKT_W].
REQ-008 done  output  NUM_REQ  one-cycle pulse on bit i: requester i's packet fully sent.
REQ-009 err  output  NUM_REQ  one-cycle pulse on bit i: requester i's packet aborted by timeout.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 snd_data  output  PKT_W  registered packet driven to the shared serial sender.
REQ-012 snd_start  output  1  level start to the shared sender; high only in SEND.
REQ-013 snd_done  input  1  sender completion pulse, one cycle.

Function
REQ-014 FSM states SHALL be IDLE, GRANT, SEND, RELEASE; all outputs registered.
REQ-015 IDLE: if any req bit high, pick winner by round-robin starting at index ptr, register winner index, go GRANT; else stay.
REQ-016 GRANT: snd_data SHALL load pkt slice of winner; go SEND next cycle; snd_start rises 2 cycles after req sampled in IDLE.
REQ-017 SEND: snd_start=1; 32-bit timer increments from 0 each cycle.
REQ-018 SEND and snd_done=1: go RELEASE, flag success.
REQ-019 SEND and timer==TIMEOUT_CYC-1 with snd_done=0: go RELEASE, flag timeout.
REQ-020 snd_done and timeout in same cycle: success wins.
REQ-021 RELEASE: pulse done[winner] (success) or err[winner] (timeout) for exactly one cycle; snd_start=0; ptr <= (winner+1) mod NUM_REQ; timer cleared; go IDLE.
REQ-022 At least one IDLE cycle between consecutive grants; back-to-back transfers are never overlapped.
REQ-023 snd_data SHALL hold its value from GRANT until the next GRANT; pkt changes after GRANT are ignored.
REQ-024 req drop during GRANT/SEND is ignored; the transfer completes and done/err still pulse.
REQ-025 snd_done outside SEND is ignored.
REQ-026 Requester whose req stays high after its done is re-arbitrated with lowest priority (round-robin wrap).
REQ-027 ptr wraps from NUM_REQ-1 to 0.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, ptr 0, timer 0, winner 0, done 0, err 0, busy 0, snd_start 0, snd_data 0.
REQ-029 Reset during GRANT/SEND aborts the transfer with no done/err pulse; arbitration restarts from index 0 after release.

Structure
REQ-030 Shared package uart_arb_pkg SHALL hold the 2-bit state encoding (IDLE=0, GRANT=1, SEND=2, RELEASE=3) and default parameter constants.
REQ-031 One sub-module rr_picker (combinational round-robin priority encoder: req, ptr -> valid, index) SHALL be used.

Verification
REQ-032 Single req[2] with pkt slice 0xA5.., sender done after 50 cycles -> snd_start at cycle +2, snd_data = slice 2, done[2] pulse once, ptr=3.
REQ-033 req=4'b1111 held, ptr=0 -> grants in order 0,1,2,3,0; each done pulse exactly one cycle; busy low one cycle between grants.
REQ-034 TIMEOUT_CYC=100, snd_done never asserted -> snd_start high exactly 100 cycles, err[winner] pulse, no done.
REQ-035 snd_done coincident with timer==TIMEOUT_CYC-1 -> done pulse, no err.
REQ-036 rst_n low mid-SEND with req=4'b0010 -> all outputs 0 asynchronously, no done/err; after release, req[1] regranted from ptr 0.
REQ-037 pkt for winner changed during SEND, req dropped mid-SEND -> snd_data unchanged, done still pulses.
